// File: rtl/fifo_bus_sel_arbiter_pkg.sv
// fifo_bus_sel_arbiter_pkg: shared FSM encoding and clog2 helper for the bus-select arbiter
package fifo_bus_sel_arbiter_pkg;
   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/fifo_bus_sel_arbiter_rr_arbiter_pick.sv
// rr_arbiter_pick: combinational round-robin pick, first set request at or above ptr (wrapping)
//   req  : request vector
//   ptr  : search start index
//   pick : one-hot chosen request (0 when req is 0)
//   idx  : index of pick
module rr_arbiter_pick #(
   parameter int PORT_NUM = 2,
   parameter int PTR_W    = 1
) (
   input  logic [PORT_NUM-1:0] req,
   input  logic [PTR_W-1:0]    ptr,
   output logic [PORT_NUM-1:0] pick,
   output logic [PTR_W-1:0]    idx
);
   int c;
   // Scan offsets from farthest to nearest so the nearest request overwrites.
   always_comb begin
      pick = '0;
      idx  = '0;
      c    = 0;
      for (int i = PORT_NUM - 1; i >= 0; i--) begin
         c = (int'(ptr) + i) % PORT_NUM;
         if (req[c]) begin
            pick    = '0;
            pick[c] = 1'b1;
            idx     = PTR_W'(c);
         end
      end
   end
endmodule

// File: rtl/fifo_bus_sel_arbiter.sv
// fifo_bus_sel_arbiter: round-robin frame arbiter muxing granted port data into one FIFO
//   clk, rst     : clock, async active-high reset
//   bus_sel      : per-port request vector
//   din          : packed port data, port x at [x*DATA_W +: DATA_W]
//   din_valid    : per-port valid
//   din_eof      : per-port end-of-frame, qualified by valid
//   fifo_full    : FIFO cannot take a write
//   grant        : one-hot grant (held for a whole frame)
//   ready        : per-port accept strobe
//   fifo_wr_en, fifo_wdata, fifo_wr_eof : registered FIFO write interface
module fifo_bus_sel_arbiter
   import fifo_bus_sel_arbiter_pkg::*;
#(
   parameter int PORT_NUM = 2,
   parameter int DATA_W   = 8,
   parameter int PTR_W    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PORT_NUM-1:0]        bus_sel,
   input  logic [PORT_NUM*DATA_W-1:0] din,
   input  logic [PORT_NUM-1:0]        din_valid,
   input  logic [PORT_NUM-1:0]        din_eof,
   input  logic                       fifo_full,
   output logic [PORT_NUM-1:0]        grant,
   output logic [PORT_NUM-1:0]        ready,
   output logic                       fifo_wr_en,
   output logic [DATA_W-1:0]          fifo_wdata,
   output logic                       fifo_wr_eof
);
   if (PTR_W != clog2(PORT_NUM)) begin : g_bad_ptr_w
      $error("PTR_W must equal clog2(PORT_NUM)");
   end
   state_t             state;
   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    g;
   logic [PORT_NUM-1:0] pick;
   logic [PTR_W-1:0]    pick_idx;
   logic                beat;
   rr_arbiter_pick #(.PORT_NUM(PORT_NUM), .PTR_W(PTR_W)) u_pick (
      .req  (bus_sel),
      .ptr  (rr_ptr),
      .pick (pick),
      .idx  (pick_idx)
   );
   assign ready = grant & {PORT_NUM{~fifo_full}};
   // grant is zero outside XFER, so ready[g] alone qualifies the beat.
   assign beat  = din_valid[g] & ready[g];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         rr_ptr      <= '0;
         g           <= '0;
         fifo_wr_en  <= 1'b0;
         fifo_wdata  <= '0;
         fifo_wr_eof <= 1'b0;
      end else begin
         fifo_wr_en  <= beat;
         fifo_wr_eof <= beat & din_eof[g];
         if (beat) fifo_wdata <= din[g*DATA_W +: DATA_W];
         if (state == IDLE && |bus_sel) begin
            grant <= pick;
            g     <= pick_idx;
            state <= XFER;
         end else if (state == XFER && beat && din_eof[g]) begin
            grant  <= '0;
            rr_ptr <= (g == PTR_W'(PORT_NUM - 1)) ? '0 : g + 1'b1;
            state  <= IDLE;
         end
      end
   end
endmodule
